// File: rtl/mem_stall_ctrl.sv
// Memory-stall controller: one outstanding request per port, stale-response discard
// after flush, global pipeline stall, sticky protocol/timeout errors, stall-cycle count.
module mem_stall_ctrl #(
  parameter int NUM_PORTS = 2,
  parameter int TIMEOUT_W = 10,
  parameter int TIMEOUT   = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] resp,
  input  logic [NUM_PORTS-1:0] flush,
  output logic [NUM_PORTS-1:0] resp_ok,
  output logic [NUM_PORTS-1:0] resp_drop,
  output logic [NUM_PORTS-1:0] busy,
  output logic                 stall,
  output logic [NUM_PORTS-1:0] proto_err,
  output logic [NUM_PORTS-1:0] timeout_err,
  output logic [31:0]          stall_cycles
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DRAIN_Q = 2'd3;

  localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT);

  logic [1:0]           state     [NUM_PORTS];
  logic [1:0]           state_nxt [NUM_PORTS];
  logic [TIMEOUT_W-1:0] cnt       [NUM_PORTS];
  logic [TIMEOUT_W-1:0] cnt_nxt   [NUM_PORTS];
  logic [NUM_PORTS-1:0] stale_q, stale_nxt, perr_set, tout_set, stall_vec;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      state_nxt[p] = state[p];
      stale_nxt[p] = stale_q[p];
      perr_set[p]  = 1'b0;
      resp_ok[p]   = 1'b0;
      resp_drop[p] = 1'b0;
      case (state[p])
        IDLE: begin
          if (req[p]) begin
            state_nxt[p] = WAIT;
            stale_nxt[p] = 1'b0;
          end
        end
        WAIT: begin
          if (resp[p]) begin
            resp_ok[p]   = ~flush[p];
            resp_drop[p] = flush[p];
            state_nxt[p] = req[p] ? WAIT : IDLE;
          end else if (flush[p]) begin
            state_nxt[p] = req[p] ? DRAIN_Q : DRAIN;
          end else if (req[p]) begin
            perr_set[p] = 1'b1;
          end
        end
        DRAIN: begin
          if (resp[p]) begin
            resp_drop[p] = 1'b1;
            state_nxt[p] = req[p] ? WAIT : IDLE;
          end else if (req[p]) begin
            state_nxt[p] = DRAIN_Q;
          end
        end
        default: begin
          perr_set[p] = req[p];
          // A flush landing with the draining response stales the queued request too
          if (resp[p]) begin
            resp_drop[p] = 1'b1;
            state_nxt[p] = (stale_q[p] | flush[p]) ? DRAIN : WAIT;
            stale_nxt[p] = 1'b0;
          end else if (flush[p]) begin
            stale_nxt[p] = 1'b1;
          end
        end
      endcase

      stall_vec[p] = ((state[p] == WAIT) && !resp_ok[p]) || (state[p] == DRAIN_Q);

      if (state_nxt[p] == IDLE || resp[p])
        cnt_nxt[p] = '0;
      else if (TIMEOUT != 0 && cnt[p] != TO_LIM)
        cnt_nxt[p] = cnt[p] + 1'b1;
      else
        cnt_nxt[p] = cnt[p];
      tout_set[p] = (TIMEOUT != 0) && (cnt_nxt[p] == TO_LIM);

      if (rst) begin
        resp_ok[p]   = 1'b0;
        resp_drop[p] = 1'b0;
        stall_vec[p] = 1'b0;
      end
      busy[p] = (state[p] != IDLE);
    end
  end

  assign stall = |stall_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state[p] <= IDLE;
        cnt[p]   <= '0;
      end
      stale_q      <= '0;
      proto_err    <= '0;
      timeout_err  <= '0;
      stall_cycles <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state[p] <= state_nxt[p];
        cnt[p]   <= cnt_nxt[p];
      end
      stale_q     <= stale_nxt;
      proto_err   <= proto_err | perr_set;
      timeout_err <= timeout_err | tout_set;
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl: per-cycle expected outputs go through a scoreboard queue.
module tb_mem_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0, resp = '0, flush = '0;
  logic [1:0]  resp_ok, resp_drop, busy, proto_err, timeout_err;
  logic        stall;
  logic [31:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [6:0] v;   // {resp_ok, resp_drop, busy, stall}
  } exp_t;
  exp_t sb[$];

  mem_stall_ctrl #(.NUM_PORTS(2), .TIMEOUT_W(10), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .resp(resp), .flush(flush),
    .resp_ok(resp_ok), .resp_drop(resp_drop), .busy(busy), .stall(stall),
    .proto_err(proto_err), .timeout_err(timeout_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, compare combinational/registered outputs mid-cycle
  task automatic step(input logic [1:0] rq, input logic [1:0] rs, input logic [1:0] fl,
                      input logic [1:0] e_ok, input logic [1:0] e_drop,
                      input logic [1:0] e_busy, input logic e_stall, input string tag);
    exp_t e, got;
    logic [6:0] obs;
    @(posedge clk);
    #1;
    req = rq; resp = rs; flush = fl;
    e.tag = tag;
    e.v   = {e_ok, e_drop, e_busy, e_stall};
    sb.push_back(e);
    #2;
    obs = {resp_ok, resp_drop, busy, stall};
    got = sb.pop_front();
    tests++;
    assert (obs === got.v) else begin
      fails++;
      $error("FAIL %s: got ok/drop/busy/stall=%b expected %b", got.tag, obs, got.v);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    req = '0; resp = '0; flush = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #2;
    chk("reset_outputs", {25'd0, resp_ok, resp_drop, busy, stall}, 32'd0);
    #10;
    rst = 1'b0;
    chk("reset_errs", {28'd0, proto_err, timeout_err}, 32'd0);
    chk("reset_cnt", stall_cycles, 32'd0);

    // single imem request, response after three cycles
    step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t1_c0");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, "t1_c1");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, "t1_c2");
    step(2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0, "t1_c3");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t1_c4");
    chk("t1_stall_cycles", stall_cycles, 32'd2);

    // flush, re-request while draining, stale response dropped
    do_reset();
    step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t2_c0");
    step(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, "t2_c1");
    step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, "t2_c2_drain");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, "t2_c3_drainq");
    step(2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1, "t2_c4_drop");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, "t2_c5");
    step(2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0, "t2_c6_ok");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t2_c7");
    chk("t2_proto_err", {30'd0, proto_err}, 32'd0);
    chk("t2_stall_cycles", stall_cycles, 32'd4);

    // both ports outstanding, dmem answers first
    do_reset();
    step(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t3_c0");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, "t3_c1");
    step(2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 1'b1, "t3_c2");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, "t3_c3");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, "t3_c4");
    step(2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0, "t3_c5");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t3_c6");
    chk("t3_stall_cycles", stall_cycles, 32'd4);

    // second request while waiting is illegal and ignored
    do_reset();
    step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t5_c0");
    step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, "t5_c1");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, "t5_c2");
    chk("t5_proto_err", {30'd0, proto_err}, 32'd1);
    step(2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0, "t5_c3");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t5_c4");
    chk("t5_proto_sticky", {30'd0, proto_err}, 32'd1);

    // dmem never answers: timeout after 8 cycles, cleared by reset, late response ignored
    do_reset();
    step(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t4_c0");
    for (int i = 1; i < 8; i++)
      step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, "t4_wait");
    chk("t4_no_timeout_c7", {30'd0, timeout_err}, 32'd0);
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, "t4_c8");
    chk("t4_timeout_c8", {30'd0, timeout_err}, 32'd2);
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, "t4_c9");
    chk("t4_timeout_sticky", {30'd0, timeout_err}, 32'd2);
    do_reset();
    chk("t4_timeout_cleared", {30'd0, timeout_err}, 32'd0);
    chk("t4_cnt_cleared", stall_cycles, 32'd0);
    step(2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t4_stale_resp");

    // asynchronous reset mid-cycle with both ports waiting and responses present
    do_reset();
    step(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t6_c0");
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, "t6_c1");
    step(2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, "t6_c2");
    rst = 1'b1;
    #1;
    chk("t6_async_outputs", {25'd0, resp_ok, resp_drop, busy, stall}, 32'd0);
    #1;
    rst = 1'b0;
    resp = '0;
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "t6_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
